// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo: captures {delta, count} pairs from a free-running counter on
// each rising edge of trig. The pairs queue in a show-ahead FIFO that a valid/ready
// port drains. A capture that finds the FIFO full is dropped, and the drop is
// reported through a sticky overflow flag and a saturating drop counter.
module count_snapshot_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 trig,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        level,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  // Edge detector and capture tracking
  logic             trig_q;
  logic [WIDTH-1:0] last_cap_q, last_cap_d;

  // FIFO storage and bookkeeping
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic             trig_edge;
  logic [WIDTH-1:0] delta;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;

  // Decode the edge and the push/pop/drop decisions for this cycle
  always_comb begin
    trig_edge = trig & ~trig_q;
    // Modular difference; the wrap is intentional so delta is the true spacing.
    delta     = count_in - last_cap_q;
    full      = (level_q == LevelFull);
    empty     = (level_q == '0);
    pop       = ~empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push      = trig_edge & (~full | pop);
    drop      = trig_edge & full & ~pop;
  end

  // Next-state for pointers, occupancy, last capture and overflow reporting
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_cap_d = last_cap_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Dropped captures still advance last_cap so later deltas stay honest.
    if (trig_edge) begin
      last_cap_d = count_in;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hff) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // Control state; trig_q resets high so a trig held across reset is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q     <= 1'b1;
      last_cap_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      trig_q     <= trig;
      last_cap_q <= last_cap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= {delta, count_in};
    end
  end

  // Registered-only outputs; out_ready never reaches out_valid or out_data
  always_comb begin
    out_data  = mem_q[rd_ptr_q];
    out_valid = ~empty;
    level     = level_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo (WIDTH=8, DEPTH=4).
module tb_count_snapshot_fifo;

  logic        clk;
  logic        reset;
  logic [7:0]  count_in;
  logic        trig;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int total;
  int bad;

  count_snapshot_fifo #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .trig     (trig),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle trig pulse followed by one low cycle.
  task automatic pulse(input logic [7:0] cnt);
    count_in = cnt;
    trig     = 1'b1;
    step();
    trig     = 1'b0;
    step();
  endtask

  // Check the head entry, then pop it.
  task automatic pop_check(input string tag, input logic [7:0] d, input logic [7:0] c);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'({d, c}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    trig      = 1'b0;
    count_in  = 8'd0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Basic capture
    pulse(8'd10);
    check("basic_level1", 32'(level), 32'd1);
    pulse(8'd25);
    check("basic_level2", 32'(level), 32'd2);
    pop_check("basic_e0", 8'd10, 8'd10);
    pop_check("basic_e1", 8'd15, 8'd25);
    check("basic_empty", 32'(out_valid), 32'd0);
    check("basic_level0", 32'(level), 32'd0);

    // Wrap: last_cap=25 -> delta 225, then 4-250 mod 256 = 10
    pulse(8'd250);
    pulse(8'd4);
    pop_check("wrap_e0", 8'd225, 8'd250);
    pop_check("wrap_e1", 8'd10, 8'd4);

    // Overflow: last_cap=4, fifth edge at 9 dropped
    pulse(8'd1);
    pulse(8'd3);
    pulse(8'd5);
    pulse(8'd7);
    check("ovf_pre_flag", 32'(overflow), 32'd0);
    pulse(8'd9);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    pop_check("ovf_e0", 8'd253, 8'd1);
    pop_check("ovf_e1", 8'd2, 8'd3);
    pop_check("ovf_e2", 8'd2, 8'd5);
    pop_check("ovf_e3", 8'd2, 8'd7);
    pulse(8'd20);
    pop_check("ovf_after", 8'd11, 8'd20);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-operation with 3 entries queued and overflow set
    pulse(8'd30);
    pulse(8'd31);
    pulse(8'd32);
    check("mid_level3", 32'(level), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_level", 32'(level), 32'd0);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    check("mid_drop", 32'(drop_cnt), 32'd0);
    step();
    pulse(8'd7);
    pop_check("mid_first", 8'd7, 8'd7);

    // Full plus simultaneous push and pop; last_cap=7
    pulse(8'd40);
    pulse(8'd41);
    pulse(8'd42);
    pulse(8'd43);
    check("sim_full", 32'(level), 32'd4);
    count_in  = 8'd44;
    trig      = 1'b1;
    out_ready = 1'b1;
    step();
    trig      = 1'b0;
    out_ready = 1'b0;
    check("sim_level", 32'(level), 32'd4);
    check("sim_ovf", 32'(overflow), 32'd0);
    check("sim_drop", 32'(drop_cnt), 32'd0);
    step();
    pop_check("sim_e1", 8'd1, 8'd41);
    pop_check("sim_e2", 8'd1, 8'd42);
    pop_check("sim_e3", 8'd1, 8'd43);
    pop_check("sim_e4", 8'd1, 8'd44);
    check("sim_empty", 32'(out_valid), 32'd0);

    // trig held high for 10 cycles yields one entry; last_cap=44
    count_in = 8'd50;
    trig     = 1'b1;
    for (int i = 0; i < 10; i++) step();
    trig = 1'b0;
    step();
    check("hold_level", 32'(level), 32'd1);
    pop_check("hold_e0", 8'd6, 8'd50);

    // trig high through reset release gives no capture
    trig  = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rsttrig_level", 32'(level), 32'd0);
    trig = 1'b0;
    step();
    check("rsttrig_fall", 32'(level), 32'd0);
    pulse(8'd60);
    check("rsttrig_level1", 32'(level), 32'd1);
    pop_check("rsttrig_e0", 8'd60, 8'd60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
